jtag_tap_dev: RTL
=================

JTAG_TAP_DEV -- requirements
Module: jtag_tap_dev

Interface
REQ-001 SHALL have parameter IrWidth, default 5: instruction register width.
REQ-002 SHALL have parameter IdcodeValue, default 32'h0000_0001: value captured for IDCODE; bit 0 is always 1.
REQ-003 SHALL have parameter UserDrWidth, default 32: width of the user data register.
REQ-004 SHALL have port clk_i, input, 1: the single system clock; all flops run on it.
REQ-005 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port tck_i, input, 1: JTAG clock, asynchronous to clk_i.
REQ-007 SHALL have port trst_ni, input, 1: JTAG test reset, asynchronous, active-low.
REQ-008 SHALL have port tms_i, input, 1: test mode select.
REQ-009 SHALL have port tdi_i, input, 1: serial data in.
REQ-010 SHALL have port tdo_o, output, 1: serial data out.
REQ-011 SHALL have port tdo_oe_o, output, 1: tdo drive enable; high only in Shift-DR and Shift-IR.
REQ-012 SHALL have port user_dr_i, input, UserDrWidth: value loaded in Capture-DR when USER is selected.
REQ-013 SHALL have port user_dr_o, output, UserDrWidth: value shifted in by the host.
REQ-014 SHALL have port user_dr_valid_o, output, 1: one-clk_i pulse when user_dr_o updates.
REQ-015 SHALL have port tap_state_o, output, 4: current TAP state, for debug and coverage.

Function
REQ-016 SHALL synchronise tck_i, tms_i, tdi_i and trst_ni through 2-flop synchronisers into clk_i.
REQ-017 SHALL detect tck rise and tck fall from the synchronised tck, each as a one-cycle strobe.
REQ-018 SHALL require f(clk_i) >= 4x f(tck_i); behaviour is undefined below this ratio.
REQ-019 SHALL advance the 16-state IEEE 1149.1 TAP FSM only on a tck-rise strobe, using the synchronised tms: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
REQ-020 SHALL encode states in a 4-bit enum and drive tap_state_o from that encoding.
REQ-021 SHALL reach TLR after five consecutive tck rises with tms=1, from any state.
REQ-022 SHALL select instructions as follows: IDCODE=5'h01, USER=5'h10, BYPASS=all ones; any other code behaves as BYPASS.
REQ-023 SHALL load IR shift register with ...01 (LSBs 2'b01, rest 0) at a CapIR tck rise.
REQ-024 SHALL shift LSB first on each tck rise while in ShIR or ShDR: tdi enters the MSB, and the shift register shifts right.
REQ-025 SHALL copy the IR shift register to the active IR at the tck fall in UpdIR.
REQ-026 SHALL select DR by active IR: IDCODE gives 32-bit IdcodeValue, BYPASS gives 1 bit (captures 0), USER gives UserDrWidth bits (captures user_dr_i).
REQ-027 SHALL load user_dr_o from the DR shift register at the tck fall in UpdDR with USER active, and SHALL pulse user_dr_valid_o in that same clk_i cycle.
REQ-028 SHALL update tdo_o on tck fall only, to the LSB of the active shift register; tdo_o holds its value otherwise.
REQ-029 SHALL update tdo_oe_o on tck fall: high iff the state is ShDR or ShIR.
REQ-030 SHALL ignore a tck rise and a tck fall that fall in the same clk_i cycle; this cannot occur at the ratio in REQ-018.

Reset
REQ-031 SHALL, on rst_i high (asynchronous), set state=TLR, active IR=IDCODE, shift registers=0, user_dr_o=0, user_dr_valid_o=0, tdo_o=0, tdo_oe_o=0, and clear the synchronisers.
REQ-032 SHALL apply synchronised trst_ni=0 as a TAP reset with the same values as REQ-031 except user_dr_o, which holds its value.
REQ-033 SHALL, while in TLR, force active IR=IDCODE on every cycle.
REQ-034 SHALL, on reset mid-shift, discard the partial shift and suppress any update pulse.

Structure
REQ-035 SHALL define tap_state_e, the instruction codes and IrWidth default in jtag_tap_pkg.
REQ-036 SHALL implement the synchroniser and edge detect as sub-module jtag_tck_sync.
REQ-037 SHALL keep the FSM and registers in jtag_tap_dev itself.

Verification
REQ-038 Reset IDCODE read: after rst_i pulse, drive tms 0,1,0,0 then shift 32 bits -> tdo yields 32'h0000_0001 LSB first; tdo_oe_o=1 only during the 32 shift cycles.
REQ-039 IR capture/BYPASS: shift IR 5'h1F -> tdo returns 5'b00001; then shift DR with tdi pattern 8'hA5 -> tdo emits 0 followed by 8'hA5 delayed by one bit.
REQ-040 USER write/read: IR=5'h10, user_dr_i=32'hDEAD_BEEF, shift in 32'h1234_5678 -> tdo yields 32'hDEAD_BEEF; user_dr_o becomes 32'h1234_5678 with a single user_dr_valid_o pulse.
REQ-041 TMS reset: from PauseDR, five tck rises with tms=1 -> tap_state_o=TLR, IR=IDCODE, no user_dr_valid_o pulse.
REQ-042 Async reset mid-shift: assert rst_i after 10 of 32 USER shift bits -> all outputs reset next cycle and user_dr_o stays 0.
REQ-043 Clock ratio sweep: run REQ-040 at clk:tck ratios 4, 7 and 20 -> identical tdo and user_dr_o results.

Source files
------------

// File: rtl/jtag_tap_pkg.sv
// Shared types and constants for the JTAG TAP device: state encoding and
// instruction codes.
package jtag_tap_pkg;

    localparam int unsigned IR_WIDTH_DEFAULT = 5;

    localparam logic [4:0] INSTR_IDCODE = 5'h01;
    localparam logic [4:0] INSTR_USER   = 5'h10;
    localparam logic [4:0] INSTR_BYPASS = 5'h1F;

    typedef enum logic [3:0] {
        TLR      = 4'h0,
        RTI      = 4'h1,
        SEL_DR   = 4'h2,
        CAP_DR   = 4'h3,
        SH_DR    = 4'h4,
        EX1_DR   = 4'h5,
        PAUSE_DR = 4'h6,
        EX2_DR   = 4'h7,
        UPD_DR   = 4'h8,
        SEL_IR   = 4'h9,
        CAP_IR   = 4'hA,
        SH_IR    = 4'hB,
        EX1_IR   = 4'hC,
        PAUSE_IR = 4'hD,
        EX2_IR   = 4'hE,
        UPD_IR   = 4'hF
    } tap_state_e;

    // The IR column of the state diagram occupies the upper half of the encoding.
    function automatic logic is_ir_side(tap_state_e s);
        return s >= SEL_IR;
    endfunction

endpackage

// File: rtl/jtag_tck_sync.sv
// Brings the JTAG pins into the clk domain through 2-flop synchronisers and
// turns the synchronised tck into one-cycle rise/fall strobes.
module jtag_tck_sync (
    input  logic clk,
    input  logic rst,
    input  logic tck_i,
    input  logic tms_i,
    input  logic tdi_i,
    input  logic trst_ni,
    output logic tck_rise,
    output logic tck_fall,
    output logic tms_s,
    output logic tdi_s,
    output logic trst_ns
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;
    logic       tck_prev_q;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q     <= '0;
            sync_q     <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            meta_q     <= {trst_ni, tdi_i, tms_i, tck_i};
            sync_q     <= meta_q;
            tck_prev_q <= sync_q[0];
        end
    end

    // Both strobes come from one delayed pair, so they can never coincide.
    assign tck_rise = sync_q[0] & ~tck_prev_q;
    assign tck_fall = ~sync_q[0] & tck_prev_q;
    assign tms_s    = sync_q[1];
    assign tdi_s    = sync_q[2];
    assign trst_ns  = sync_q[3];

endmodule

// File: rtl/jtag_tap_dev.sv
// IEEE 1149.1 TAP device oversampled by clk_i: IDCODE, BYPASS and a USER data
// register that hands host-written values to the system side.
module jtag_tap_dev
    import jtag_tap_pkg::*;
#(
    parameter int unsigned IrWidth     = IR_WIDTH_DEFAULT,
    parameter logic [31:0] IdcodeValue = 32'h0000_0001,
    parameter int unsigned UserDrWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tck_i,
    input  logic                   trst_ni,
    input  logic                   tms_i,
    input  logic                   tdi_i,
    output logic                   tdo_o,
    output logic                   tdo_oe_o,
    input  logic [UserDrWidth-1:0] user_dr_i,
    output logic [UserDrWidth-1:0] user_dr_o,
    output logic                   user_dr_valid_o,
    output logic [3:0]             tap_state_o
);

    localparam int DrW = (UserDrWidth > 32) ? int'(UserDrWidth) : 32;

    logic tck_rise, tck_fall, tms_s, tdi_s, trst_ns, tap_reset;

    jtag_tck_sync u_sync (
        .clk      (clk_i),
        .rst      (rst_i),
        .tck_i    (tck_i),
        .tms_i    (tms_i),
        .tdi_i    (tdi_i),
        .trst_ni  (trst_ni),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .tms_s    (tms_s),
        .tdi_s    (tdi_s),
        .trst_ns  (trst_ns)
    );

    assign tap_reset = ~trst_ns;

    tap_state_e         state_q, state_d;
    logic [IrWidth-1:0] ir_sr_q, ir_q;
    logic [DrW-1:0]     dr_sr_q, dr_shifted, dr_capture;
    logic               is_user, is_idcode;
    int                 dr_len;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= TLR;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (tap_reset) begin
            state_d = TLR;
        end else if (tck_rise) begin
            unique case (state_q)
                TLR:      state_d = tms_s ? TLR    : RTI;
                RTI:      state_d = tms_s ? SEL_DR : RTI;
                SEL_DR:   state_d = tms_s ? SEL_IR : CAP_DR;
                CAP_DR:   state_d = tms_s ? EX1_DR : SH_DR;
                SH_DR:    state_d = tms_s ? EX1_DR : SH_DR;
                EX1_DR:   state_d = tms_s ? UPD_DR : PAUSE_DR;
                PAUSE_DR: state_d = tms_s ? EX2_DR : PAUSE_DR;
                EX2_DR:   state_d = tms_s ? UPD_DR : SH_DR;
                UPD_DR:   state_d = tms_s ? SEL_DR : RTI;
                SEL_IR:   state_d = tms_s ? TLR    : CAP_IR;
                CAP_IR:   state_d = tms_s ? EX1_IR : SH_IR;
                SH_IR:    state_d = tms_s ? EX1_IR : SH_IR;
                EX1_IR:   state_d = tms_s ? UPD_IR : PAUSE_IR;
                PAUSE_IR: state_d = tms_s ? EX2_IR : PAUSE_IR;
                EX2_IR:   state_d = tms_s ? UPD_IR : SH_IR;
                UPD_IR:   state_d = tms_s ? SEL_DR : RTI;
                default:  state_d = TLR;
            endcase
        end
    end

    // Instruction decode; any unrecognised code falls through to BYPASS.
    always_comb begin
        is_user    = (ir_q == IrWidth'(INSTR_USER));
        is_idcode  = (ir_q == IrWidth'(INSTR_IDCODE));
        dr_len     = 1;
        dr_capture = '0;
        if (is_user) begin
            dr_len     = int'(UserDrWidth);
            dr_capture = DrW'(user_dr_i);
        end else if (is_idcode) begin
            dr_len     = 32;
            dr_capture = DrW'(IdcodeValue | 32'h1);
        end
    end

    // Right shift within the selected register length; tdi lands in its MSB.
    logic [DrW:0] dr_ext;
    assign dr_ext = {1'b0, dr_sr_q};

    always_comb begin
        dr_shifted = '0;
        for (int i = 0; i < DrW; i++) begin
            if (i == dr_len - 1)     dr_shifted[i] = tdi_s;
            else if (i < dr_len - 1) dr_shifted[i] = dr_ext[i+1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ir_sr_q         <= '0;
            ir_q            <= IrWidth'(INSTR_IDCODE);
            dr_sr_q         <= '0;
            user_dr_o       <= '0;
            user_dr_valid_o <= 1'b0;
            tdo_o           <= 1'b0;
            tdo_oe_o        <= 1'b0;
        end else if (tap_reset) begin
            // user_dr_o deliberately survives a TAP-only reset.
            ir_sr_q         <= '0;
            ir_q            <= IrWidth'(INSTR_IDCODE);
            dr_sr_q         <= '0;
            user_dr_valid_o <= 1'b0;
            tdo_o           <= 1'b0;
            tdo_oe_o        <= 1'b0;
        end else begin
            user_dr_valid_o <= 1'b0;
            if (tck_rise) begin
                unique case (state_q)
                    CAP_IR:  ir_sr_q <= IrWidth'(2'b01);
                    SH_IR:   ir_sr_q <= {tdi_s, ir_sr_q[IrWidth-1:1]};
                    CAP_DR:  dr_sr_q <= dr_capture;
                    SH_DR:   dr_sr_q <= dr_shifted;
                    default: ;
                endcase
            end
            if (tck_fall) begin
                tdo_o    <= is_ir_side(state_q) ? ir_sr_q[0] : dr_sr_q[0];
                tdo_oe_o <= (state_q == SH_DR) || (state_q == SH_IR);
                if (state_q == UPD_IR) ir_q <= ir_sr_q;
                if (state_q == UPD_DR && is_user) begin
                    user_dr_o       <= dr_sr_q[UserDrWidth-1:0];
                    user_dr_valid_o <= 1'b1;
                end
            end
            if (state_q == TLR) ir_q <= IrWidth'(INSTR_IDCODE);
        end
    end

    assign tap_state_o = state_q;

endmodule
